// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and default widths for the load/store controller.
// Op and state codes are kept as plain constants so older users can keep using them.
package mem_access_ctrl_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_WIPE = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter used for the access statistics.
// Once it reaches all-ones it holds there until reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the execute stage and the word-addressed data RAM.
// One request in flight; registered RAM pins are stable half a cycle before the RAM's negedge.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | req_ready high, waiting for a request
// ST_ACCESS | one cycle: RAM acts at mid-cycle negedge (ce low if rejected)
// ST_RESP   | rsp_valid held until rsp_ready
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CPU_AW = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [CPU_AW-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_ce,
    output logic              ram_rw,
    output logic              ram_clr,
    output logic [ADDR_W-1:0] ram_mar,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [1:0] state;
    logic [1:0] op_q;
    logic       err_q;
    logic       req_bad;
    logic       rd_en;
    logic       wr_en;
    logic       err_en;

    assign req_bad = (req_addr[CPU_AW-1:ADDR_W] != '0) || (req_op == OP_RSV);

    assign rd_en  = (state == ST_ACCESS) && !err_q && (op_q == OP_RD);
    assign wr_en  = (state == ST_ACCESS) && !err_q && (op_q == OP_WR);
    assign err_en = (state == ST_ACCESS) && err_q;

    // Rejected requests also spend one cycle in ACCESS (with ce low) so that
    // errors and real accesses share the same one-cycle response latency.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            op_q      <= OP_RD;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_ce    <= 1'b0;
            ram_rw    <= 1'b1;
            ram_clr   <= 1'b1;
            ram_mar   <= '0;
            ram_din   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        err_q     <= req_bad;
                        state     <= ST_ACCESS;
                        if (!req_bad) begin
                            ram_ce  <= 1'b1;
                            ram_mar <= req_addr[ADDR_W-1:0];
                            ram_din <= req_wdata;
                            ram_rw  <= (req_op != OP_WR);
                            ram_clr <= (req_op != OP_WIPE);
                        end
                    end
                end
                ST_ACCESS: begin
                    // ram_dout is only looked at when a read actually drove the bus
                    if (!err_q && (op_q == OP_RD)) begin
                        rsp_rdata <= ram_dout;
                    end else begin
                        rsp_rdata <= '0;
                    end
                    ram_ce    <= 1'b0;
                    ram_clr   <= 1'b1;
                    ram_rw    <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    ram_ce    <= 1'b0;
                    ram_clr   <= 1'b1;
                    ram_rw    <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk (clk),
        .clr (clr),
        .en  (rd_en),
        .cnt (rd_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk (clk),
        .clr (clr),
        .en  (wr_en),
        .cnt (wr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .clr (clr),
        .en  (err_en),
        .cnt (err_cnt)
    );

endmodule
